// File: rtl/func_scan_pkg.sv
// Shared types and constants for the truth-table scanner.
//   state_e  : scanner FSM state (IDLE, SCAN, DONE), 2-bit encoding
//   N_IN_MAX : largest supported number of function inputs
//   rows_of  : truth-table depth for a given input count
package func_scan_pkg;

  localparam int unsigned N_IN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned rows_of(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/func_table_scan_if.sv
// Result stream carrying one truth-table row per transfer.
//   out_valid : row available (scanner -> sink)
//   out_ready : sink accepts row (sink -> scanner)
//   out_idx   : row index, i.e. the input combination
//   out_s     : function value for that row
interface func_table_scan_if #(
  parameter int unsigned N_IN = 3
);

  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_idx;
  logic            out_s;

  modport master (
    output out_valid,
    output out_idx,
    output out_s,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_s,
    output out_ready
  );

endinterface

// File: rtl/func_scan_ctr.sv
// Row counter for the scanner.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : return to row 0 (has priority over en_i)
//   en_i       : advance one row
//   idx_o      : current row
//   last_o     : current row is the final table row
module func_scan_ctr
  import func_scan_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [N_IN-1:0] idx_o,
  output logic            last_o
);

  localparam int unsigned ROWS = rows_of(N_IN);

  logic [N_IN-1:0] idx_q, idx_d;

  // Next row value
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_q + N_IN'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == N_IN'(ROWS - 1));

endmodule

// File: rtl/func_table_scan.sv
// N-input boolean function evaluator: latches a 2^N-entry truth table on
// start and streams every (row index, value) pair to a valid/ready sink.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a sweep (honoured only while idle)
//   table_in   : truth table, bit i = f(i), index MSB = first input
//   busy       : sweep in progress (SCAN or DONE)
//   done       : one-cycle pulse after the last row is accepted
//   ones_cnt   : number of accepted rows whose value was 1
//   out_if     : result stream (master side)
// Build option: define FUNC_SCAN_ONES_EN to enable the ones counter;
// otherwise ones_cnt is constant zero.
module func_table_scan
  import func_scan_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [rows_of(N_IN)-1:0]    table_in,
  output logic                        busy,
  output logic                        done,
  output logic [N_IN:0]               ones_cnt,
  func_table_scan_if.master           out_if
);

  localparam int unsigned ROWS = rows_of(N_IN);
  localparam int unsigned CW   = N_IN + 1;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [ROWS-1:0] table_q;
  logic            load;
  logic            ctr_en;
  logic            hs;
  logic            last;
  logic [N_IN-1:0] idx;

  assign hs = valid_q & out_if.out_ready;

  func_scan_ctr #(
    .N_IN (N_IN)
  ) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (load),
    .en_i   (ctr_en),
    .idx_o  (idx),
    .last_o (last)
  );

  // Next state; status flags are derived from the next state so they are registered
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ctr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          load    = 1'b1;
        end
      end
      SCAN: begin
        if (hs) begin
          // The final row leaves the counter parked instead of wrapping
          if (last) begin
            state_d = DONE;
          end else begin
            ctr_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Truth table is captured only when a sweep is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      table_q <= '0;
    end else if (load) begin
      table_q <= table_in;
    end
  end

`ifdef FUNC_SCAN_ONES_EN
  logic [CW-1:0] ones_q, ones_d;

  // Count accepted rows that evaluate to 1; held after the sweep
  always_comb begin
    ones_d = ones_q;
    if (load) begin
      ones_d = '0;
    end else if (hs && out_if.out_s) begin
      ones_d = ones_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_cnt = ones_q;
`else
  assign ones_cnt = CW'(0);
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_idx   = idx;
  // Row value is looked up directly from the current row, no extra latency
  assign out_if.out_s     = table_q[idx];

endmodule

// File: tb/tb_func_table_scan.sv
module tb_func_table_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start3, start4;
  logic [7:0]  tbl3;
  logic [15:0] tbl4;
  logic        busy3, done3, busy4, done4;
  logic [3:0]  ones3;
  logic [4:0]  ones4;

  func_table_scan_if #(.N_IN(3)) if3 ();
  func_table_scan_if #(.N_IN(4)) if4 ();

  func_table_scan #(.N_IN(3)) u3 (
    .clk      (clk),
    .reset    (reset),
    .start    (start3),
    .table_in (tbl3),
    .busy     (busy3),
    .done     (done3),
    .ones_cnt (ones3),
    .out_if   (if3.master)
  );

  func_table_scan #(.N_IN(4)) u4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start4),
    .table_in (tbl4),
    .busy     (busy4),
    .done     (done4),
    .ones_cnt (ones4),
    .out_if   (if4.master)
  );

`ifdef FUNC_SCAN_ONES_EN
  localparam bit ONES_EN = 1'b1;
`else
  localparam bit ONES_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] tbl;
    logic [7:0] rows;   // expected out_s per row, bit i = row i
    int         ones;
    bit         poke_done;
    string      name;
  } vec_t;

  vec_t vecs [6];

  function automatic int exp_ones(input int n);
    return ONES_EN ? n : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep3(input vec_t v);
    start3 = 1'b1;
    tbl3   = v.tbl;
    tick();
    start3 = 1'b0;
    tbl3   = ~v.tbl;
    chk({v.name, "_busy"}, 32'(busy3), 32'(1));
    chk({v.name, "_valid"}, 32'(if3.out_valid), 32'(1));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_idx%0d", v.name, i), 32'(if3.out_idx), 32'(i));
      chk($sformatf("%s_s%0d", v.name, i), 32'(if3.out_s), 32'(v.rows[i]));
      tick();
    end
    chk({v.name, "_done"}, 32'(done3), 32'(1));
    chk({v.name, "_done_busy"}, 32'(busy3), 32'(1));
    chk({v.name, "_done_valid"}, 32'(if3.out_valid), 32'(0));
    chk({v.name, "_ones"}, 32'(ones3), 32'(exp_ones(v.ones)));
    if (v.poke_done) start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk({v.name, "_idle_done"}, 32'(done3), 32'(0));
    chk({v.name, "_idle_busy"}, 32'(busy3), 32'(0));
    chk({v.name, "_idle_ones"}, 32'(ones3), 32'(exp_ones(v.ones)));
    if (v.poke_done) begin
      tick();
      chk({v.name, "_poke_busy"}, 32'(busy3), 32'(0));
      chk({v.name, "_poke_valid"}, 32'(if3.out_valid), 32'(0));
    end
  endtask

  initial begin
    // f = a(c'+b'): rows 4,5,6 true
    vecs[0] = '{8'h70, 8'b0111_0000, 3, 1'b0, "a_nand_bc"};
    vecs[1] = '{8'hFF, 8'b1111_1111, 8, 1'b1, "all_ones"};
    vecs[2] = '{8'h00, 8'b0000_0000, 0, 1'b0, "all_zero"};
    // three-input xor: rows 1,2,4,7 true
    vecs[3] = '{8'h96, 8'b1001_0110, 4, 1'b0, "xor3"};
    vecs[4] = '{8'h80, 8'b1000_0000, 1, 1'b0, "and3"};
    vecs[5] = '{8'hFE, 8'b1111_1110, 7, 1'b0, "or3"};

    reset         = 1'b1;
    start3        = 1'b0;
    start4        = 1'b0;
    tbl3          = 8'h00;
    tbl4          = 16'h0000;
    if3.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy3), 32'(0));
    chk("rst_done", 32'(done3), 32'(0));
    chk("rst_valid", 32'(if3.out_valid), 32'(0));
    chk("rst_idx", 32'(if3.out_idx), 32'(0));
    chk("rst_s", 32'(if3.out_s), 32'(0));
    chk("rst_ones", 32'(ones3), 32'(0));
    reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      run_sweep3(vecs[k]);
    end

    // Sink stalls for three cycles on row 5
    start3 = 1'b1;
    tbl3   = 8'h70;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_pre_idx", 32'(if3.out_idx), 32'(5));
    if3.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_idx_c%0d", i), 32'(if3.out_idx), 32'(5));
      chk($sformatf("stall_s_c%0d", i), 32'(if3.out_s), 32'(1));
      chk($sformatf("stall_valid_c%0d", i), 32'(if3.out_valid), 32'(1));
    end
    if3.out_ready = 1'b1;
    tick();
    chk("stall_resume_idx", 32'(if3.out_idx), 32'(6));
    chk("stall_resume_s", 32'(if3.out_s), 32'(1));
    tick();
    chk("stall_idx7", 32'(if3.out_idx), 32'(7));
    chk("stall_s7", 32'(if3.out_s), 32'(0));
    tick();
    chk("stall_done", 32'(done3), 32'(1));
    chk("stall_ones", 32'(ones3), 32'(exp_ones(3)));
    tick();

    // start with a new table mid-scan must be ignored
    start3 = 1'b1;
    tbl3   = 8'h70;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    chk("midstart_idx2", 32'(if3.out_idx), 32'(2));
    start3 = 1'b1;
    tbl3   = 8'hFF;
    tick();
    start3 = 1'b0;
    for (int i = 3; i < 8; i++) begin
      chk($sformatf("midstart_idx%0d", i), 32'(if3.out_idx), 32'(i));
      chk($sformatf("midstart_s%0d", i), 32'(if3.out_s), 32'((i >= 4 && i <= 6) ? 1 : 0));
      tick();
    end
    chk("midstart_done", 32'(done3), 32'(1));
    chk("midstart_ones", 32'(ones3), 32'(exp_ones(3)));
    tick();

    // Reset in the middle of a sweep, then a fresh sweep
    start3 = 1'b1;
    tbl3   = 8'h70;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_pre_idx", 32'(if3.out_idx), 32'(3));
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy3), 32'(0));
    chk("rstmid_valid", 32'(if3.out_valid), 32'(0));
    chk("rstmid_idx", 32'(if3.out_idx), 32'(0));
    chk("rstmid_s", 32'(if3.out_s), 32'(0));
    chk("rstmid_done", 32'(done3), 32'(0));
    chk("rstmid_ones", 32'(ones3), 32'(0));
    tick();
    reset = 1'b0;
    tick();
    start3 = 1'b1;
    tbl3   = 8'h0F;
    tick();
    start3 = 1'b0;
    chk("rstnew_idx0", 32'(if3.out_idx), 32'(0));
    chk("rstnew_s0", 32'(if3.out_s), 32'(1));
    begin
      int n;
      n = 0;
      while (!done3 && n < 20) begin
        tick();
        n++;
      end
      chk("rstnew_done_seen", 32'(done3), 32'(1));
      chk("rstnew_rows", 32'(n), 32'(8));
    end
    chk("rstnew_ones", 32'(ones3), 32'(exp_ones(4)));
    tick();

    // Four-input instance: only the first and last rows are true
    start4 = 1'b1;
    tbl4   = 16'h8001;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("n4_idx%0d", i), 32'(if4.out_idx), 32'(i));
      chk($sformatf("n4_s%0d", i), 32'(if4.out_s), 32'((i == 0 || i == 15) ? 1 : 0));
      tick();
    end
    chk("n4_done", 32'(done4), 32'(1));
    chk("n4_ones", 32'(ones4), 32'(exp_ones(2)));
    tick();
    chk("n4_idle", 32'(busy4), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
